// File: rtl/phase_sequencer.sv
// phase_sequencer: phase accumulator with FTW sweep feeding the CORDIC
// sine generator; one new PHASE per SLOT-clock sample slot.
module phase_sequencer #(
   parameter int ACC_W   = 24,
   parameter int PHASE_W = 12,
   parameter int SLOT    = 16
) (
   input  logic               CORDIC_CLK,
   input  logic               RESET,
   input  logic               ENABLE,
   input  logic               CFG_VALID,
   output logic               CFG_READY,
   input  logic [ACC_W-1:0]   CFG_FTW,
   input  logic [ACC_W-1:0]   CFG_FTW_END,
   input  logic [ACC_W-1:0]   CFG_STEP,
   input  logic [1:0]         CFG_MODE,
   input  logic [1:0]         CFG_FORM,
   output logic [PHASE_W-1:0] PHASE,
   output logic [1:0]         FORM,
   output logic               SAMPLE_STB,
   output logic               SWEEP_DONE,
   output logic               BUSY
);

   localparam int CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOT - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W-1:0]   ftw_cur_q, ftw_cur_d;
   logic [ACC_W-1:0]   ftw_start_q, ftw_start_d;
   logic [ACC_W-1:0]   ftw_end_q, ftw_end_d;
   logic [ACC_W-1:0]   step_q, step_d;
   logic [1:0]         mode_q, mode_d;
   logic               dir_q, dir_d;
   logic               pending_q, pending_d;
   logic [ACC_W-1:0]   sh_ftw_q, sh_ftw_d;
   logic [ACC_W-1:0]   sh_end_q, sh_end_d;
   logic [ACC_W-1:0]   sh_step_q, sh_step_d;
   logic [1:0]         sh_mode_q, sh_mode_d;
   logic [1:0]         sh_form_q, sh_form_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [1:0]         form_q, form_d;
   logic               stb_q, stb_d;
   logic               done_q, done_d;

   logic [ACC_W-1:0] acc_sum;
   logic [ACC_W:0]   up_sum;
   logic [ACC_W:0]   lo_lim;
   logic             boundary;
   logic             apply;
   logic             sweep_ok;

   // Sweep compares run one bit wider so START+STEP / CUR+STEP never wrap
   assign acc_sum  = acc_q + ftw_cur_q;
   assign up_sum   = {1'b0, ftw_cur_q} + {1'b0, step_q};
   assign lo_lim   = {1'b0, ftw_start_q} + {1'b0, step_q};
   assign sweep_ok = (step_q != '0) && (ftw_start_q <= ftw_end_q);
   assign boundary = (state_q != IDLE) && (cnt_q == LAST);
   assign apply    = pending_q && ((state_q == IDLE) || boundary);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      ftw_cur_d   = ftw_cur_q;
      ftw_start_d = ftw_start_q;
      ftw_end_d   = ftw_end_q;
      step_d      = step_q;
      mode_d      = mode_q;
      dir_d       = dir_q;
      pending_d   = pending_q;
      sh_ftw_d    = sh_ftw_q;
      sh_end_d    = sh_end_q;
      sh_step_d   = sh_step_q;
      sh_mode_d   = sh_mode_q;
      sh_form_d   = sh_form_q;
      phase_d     = phase_q;
      form_d      = form_q;
      stb_d       = 1'b0;
      done_d      = done_q;

      if (state_q == IDLE) begin
         cnt_d = '0;
         if (ENABLE) state_d = RUN;
      end else begin
         cnt_d = boundary ? '0 : cnt_q + 1'b1;
      end

      if (boundary) begin
         acc_d   = acc_sum;
         phase_d = acc_sum[ACC_W-1 -: PHASE_W];
         stb_d   = 1'b1;
         if ((state_q == RUN) && sweep_ok) begin
            case (mode_q)
               2'b01: begin
                  if (up_sum >= {1'b0, ftw_end_q}) begin
                     ftw_cur_d = ftw_end_q;
                     state_d   = DONE;
                     done_d    = 1'b1;
                  end else begin
                     ftw_cur_d = up_sum[ACC_W-1:0];
                  end
               end
               2'b10: begin
                  if (!dir_q) begin
                     if (up_sum >= {1'b0, ftw_end_q}) begin
                        ftw_cur_d = ftw_end_q;
                        dir_d     = 1'b1;
                     end else begin
                        ftw_cur_d = up_sum[ACC_W-1:0];
                     end
                  end else if ({1'b0, ftw_cur_q} <= lo_lim) begin
                     ftw_cur_d = ftw_start_q;
                     dir_d     = 1'b0;
                  end else begin
                     ftw_cur_d = ftw_cur_q - step_q;
                  end
               end
               default: ;
            endcase
         end
         if (!ENABLE) state_d = IDLE;
      end

      if (CFG_VALID && !pending_q) begin
         sh_ftw_d  = CFG_FTW;
         sh_end_d  = CFG_FTW_END;
         sh_step_d = CFG_STEP;
         sh_mode_d = CFG_MODE;
         sh_form_d = CFG_FORM;
         pending_d = 1'b1;
      end

      // New config wins over this slot's sweep result; ACC stays continuous
      if (apply) begin
         ftw_cur_d   = sh_ftw_q;
         ftw_start_d = sh_ftw_q;
         ftw_end_d   = sh_end_q;
         step_d      = sh_step_q;
         mode_d      = sh_mode_q;
         form_d      = sh_form_q;
         dir_d       = 1'b0;
         done_d      = 1'b0;
         pending_d   = 1'b0;
         if (state_d == DONE) state_d = RUN;
      end
   end

   always_ff @(posedge CORDIC_CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         ftw_cur_q   <= '0;
         ftw_start_q <= '0;
         ftw_end_q   <= '0;
         step_q      <= '0;
         mode_q      <= 2'b00;
         dir_q       <= 1'b0;
         pending_q   <= 1'b0;
         sh_ftw_q    <= '0;
         sh_end_q    <= '0;
         sh_step_q   <= '0;
         sh_mode_q   <= 2'b00;
         sh_form_q   <= 2'b00;
         phase_q     <= '0;
         form_q      <= 2'b00;
         stb_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         ftw_cur_q   <= ftw_cur_d;
         ftw_start_q <= ftw_start_d;
         ftw_end_q   <= ftw_end_d;
         step_q      <= step_d;
         mode_q      <= mode_d;
         dir_q       <= dir_d;
         pending_q   <= pending_d;
         sh_ftw_q    <= sh_ftw_d;
         sh_end_q    <= sh_end_d;
         sh_step_q   <= sh_step_d;
         sh_mode_q   <= sh_mode_d;
         sh_form_q   <= sh_form_d;
         phase_q     <= phase_d;
         form_q      <= form_d;
         stb_q       <= stb_d;
         done_q      <= done_d;
      end
   end

   assign CFG_READY  = !pending_q;
   assign PHASE      = phase_q;
   assign FORM       = form_q;
   assign SAMPLE_STB = stb_q;
   assign SWEEP_DONE = done_q;
   assign BUSY       = (state_q != IDLE);

endmodule
